alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Write-back stage directly downstream of the ADD/ADC execute unit.
- Accepts one result per handshake: Rd value, destination index, and the flag set already resolved by the execute unit.
- Owns the architectural N/Z/C flag register; its outputs feed the execute unit's carry_in / zero_in / neg_in.
- Buffers register-file writes in a small in-order queue, drains them over a write/ack handshake, and redirects writes to r15 as a branch request.

Parameters:
- DATA_W, 32, result and register width.
- ADDR_W, 4, register index width (r0–r15).
- DEPTH, 2, write-queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- res_valid  in  1  execute unit presents a result.
- res_ready  out  1  stage can accept this cycle.
- res_data  in  DATA_W  Rd value from execute.
- res_addr  in  ADDR_W  destination register index.
- res_wr  in  1  result must be written to a register.
- res_s  in  1  flag update requested (S bit).
- res_c  in  1  carry_out from execute.
- res_z  in  1  zero_out from execute.
- res_n  in  1  neg_out from execute.
- apsr_c  out  1  architectural C, to execute carry_in.
- apsr_z  out  1  architectural Z, to execute zero_in.
- apsr_n  out  1  architectural N, to execute neg_in.
- rf_we  out  1  register-file write request.
- rf_addr  out  ADDR_W  write index (head of queue).
- rf_wdata  out  DATA_W  write data (head of queue).
- rf_ack  in  1  register file accepted the write this cycle.
- branch_req  out  1  one-cycle pulse: PC write.
- branch_target  out  DATA_W  PC value, bit 0 forced to 0.
- chk_addr  in  ADDR_W  hazard query index from issue.
- chk_hit  out  1  a queued entry targets chk_addr.

Behaviour:
- Reset (rst low, async): queue empty (count=0, rd/wr pointers 0); apsr_c/z/n=0; rf_we=0; branch_req=0; branch_target=0; rf_addr/rf_wdata=0. Outputs stay at these values while rst is low.
- Accept: a transfer occurs when res_valid & res_ready at a rising edge.
- res_ready = (count<DEPTH) | (rf_we & rf_ack). It may depend combinationally on rf_ack and must not depend on res_valid.
- Flags: on accept with res_s=1, register apsr_c/z/n <= res_c/z/n. The new values are visible the cycle after accept, independent of queue drain.
  - res_s=0: flags hold.
- PC write: on accept with res_wr=1 and res_addr=15:
  - not enqueued;
  - next cycle branch_req=1 for exactly one cycle, branch_target = res_data with bit 0 cleared.
  - branch_target holds between pulses.
- Normal write: on accept with res_wr=1 and res_addr!=15, enqueue {addr,data} at the write pointer.
- res_wr=0: nothing enqueued; only flags may change.
- Drain:
  - rf_we = (count!=0); rf_addr/rf_wdata = head entry, registered outputs.
  - rf_addr/rf_wdata stay stable while rf_we=1 and rf_ack=0.
  - On rf_we & rf_ack, pop the head; the next entry appears the following cycle.
  - rf_ack while rf_we=0 is ignored.
- Simultaneous accept and pop: count is unchanged; both pointers advance.
  - When full, this is the only way to accept.
  - When count=1, the new entry becomes head the next cycle, so rf_we stays 1.
- Pointers wrap modulo DEPTH. count occupies 0..DEPTH; never overflows or underflows.
- chk_hit: combinational OR over valid queue entries of (entry.addr == chk_addr).
  - It excludes the entry being accepted this cycle.
  - chk_addr=15 always gives 0.
- Ordering: register writes retire strictly in accept order.
- Latency:
  - Accept to rf_we: 1 cycle when the queue is empty.
  - Accept to flag visibility: 1 cycle.
  - Accept to branch_req: 1 cycle.
- Mid-operation reset: pending queue entries and flags are discarded; no rf_we after rst deasserts until a new accept.

Test Plan:
- Reset with rst=0 mid-drain (count=2) -> rf_we=0 and apsr=000 immediately, not waiting for clk; after release, no write occurs without a new accept.
- Accept {addr=3, data=0x0000_0005, wr=1, s=1, c=1, z=0, n=0}, rf_ack=1 -> next cycle rf_we=1, rf_addr=3, rf_wdata=5, apsr_c=1; queue empty after ack.
- Hold rf_ack=0 and offer 3 results to r1, r2, r4 -> first two accepted, res_ready=0 on the third; rf_addr stays 1; chk_addr=2 gives chk_hit=1.
- Full queue, then rf_ack=1 with res_valid=1 in the same cycle -> third result accepted; count stays 2; writes retire in order r1, r2, r4.
- Accept {addr=15, data=0x0000_0101, wr=1} -> branch_req pulses for one cycle with branch_target=0x0000_0100; rf_we never asserts; chk_addr=15 gives 0.
- Accept {wr=0, s=1, z=1, n=0, c=0}, then {wr=1, s=0} -> flags become Z=1 after the first and hold through the second; only the second produces rf_we.

Source files
------------

// File: rtl/alu_writeback.sv
// Write-back stage behind the ADD/ADC execute unit. It owns the N/Z/C flags,
// queues register-file writes in order, and turns writes to r15 into branch requests.
module alu_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    input  logic [ADDR_W-1:0] res_addr,
    input  logic              res_wr,
    input  logic              res_s,
    input  logic              res_c,
    input  logic              res_z,
    input  logic              res_n,
    output logic              apsr_c,
    output logic              apsr_z,
    output logic              apsr_n,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ack,
    output logic              branch_req,
    output logic [DATA_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_hit
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(15);

    logic [DEPTH-1:0][ADDR_W-1:0] q_addr;
    logic [DEPTH-1:0][DATA_W-1:0] q_data;
    logic [DEPTH-1:0]             q_vld;
    logic [DEPTH-1:0]             hit_vec;
    logic [PTR_W-1:0]             rd_ptr, wr_ptr;
    logic [CNT_W-1:0]             count;
    logic                         pop, accept, is_pc, enq;

    assign pop       = rf_we & rf_ack;
    assign res_ready = (count < CNT_W'(DEPTH)) | pop;
    assign accept    = res_valid & res_ready;
    assign is_pc     = res_wr & (res_addr == PC_IDX);
    assign enq       = accept & res_wr & ~is_pc;

    // Head entry is read straight out of the storage registers.
    assign rf_we    = (count != '0);
    assign rf_addr  = q_addr[rd_ptr];
    assign rf_wdata = q_data[rd_ptr];

    // Hazard match per queue slot; r15 never lives in the queue.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit_vec[i] = q_vld[i] & (q_addr[i] == chk_addr);
    end
    assign chk_hit = (|hit_vec) & (chk_addr != PC_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_addr <= '0;
            q_data <= '0;
            q_vld  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Clear before set so a full-queue pop+push on one slot keeps it valid.
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && rd_ptr == PTR_W'(i))
                    q_vld[i] <= 1'b0;
                if (enq && wr_ptr == PTR_W'(i)) begin
                    q_vld[i]  <= 1'b1;
                    q_addr[i] <= res_addr;
                    q_data[i] <= res_data;
                end
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            apsr_c        <= 1'b0;
            apsr_z        <= 1'b0;
            apsr_n        <= 1'b0;
            branch_req    <= 1'b0;
            branch_target <= '0;
        end else begin
            if (accept && res_s) begin
                apsr_c <= res_c;
                apsr_z <= res_z;
                apsr_n <= res_n;
            end
            branch_req <= accept & is_pc;
            if (accept && is_pc)
                branch_target <= {res_data[DATA_W-1:1], 1'b0};
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// Randomized and directed checks of alu_writeback against a queue-based reference model.
module tb_alu_writeback;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              res_valid, res_ready;
    logic [DATA_W-1:0] res_data;
    logic [ADDR_W-1:0] res_addr;
    logic              res_wr, res_s, res_c, res_z, res_n;
    logic              apsr_c, apsr_z, apsr_n;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ack;
    logic              branch_req;
    logic [DATA_W-1:0] branch_target;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_hit;

    alu_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_addr(res_addr), .res_wr(res_wr), .res_s(res_s),
        .res_c(res_c), .res_z(res_z), .res_n(res_n),
        .apsr_c(apsr_c), .apsr_z(apsr_z), .apsr_n(apsr_n),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_ack(rf_ack),
        .branch_req(branch_req), .branch_target(branch_target),
        .chk_addr(chk_addr), .chk_hit(chk_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               mq[$];
    logic [2:0]        m_flags;   // {n,z,c}
    logic              m_br;
    logic [DATA_W-1:0] m_tgt;
    int                n_chk = 0;
    int                n_err = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flags = 3'b000;
        m_br    = 1'b0;
        m_tgt   = '0;
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic wr, input logic s, input logic c, input logic z, input logic n,
                        input logic ack, input logic [ADDR_W-1:0] ca);
        logic exp_ready, exp_hit, acc;
        @(negedge clk);
        res_valid = v; res_addr = a; res_data = d; res_wr = wr;
        res_s = s; res_c = c; res_z = z; res_n = n; rf_ack = ack; chk_addr = ca;
        #1;
        exp_ready = (mq.size() < DEPTH) || (mq.size() != 0 && ack);
        exp_hit = 1'b0;
        foreach (mq[i]) if (mq[i].addr == ca && ca != 4'd15) exp_hit = 1'b1;
        chk("res_ready", 32'(res_ready), 32'(exp_ready));
        chk("rf_we", 32'(rf_we), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("rf_addr", 32'(rf_addr), 32'(mq[0].addr));
            chk("rf_wdata", rf_wdata, mq[0].data);
        end
        chk("apsr", 32'({apsr_n, apsr_z, apsr_c}), 32'(m_flags));
        chk("branch_req", 32'(branch_req), 32'(m_br));
        chk("branch_target", branch_target, m_tgt);
        chk("chk_hit", 32'(chk_hit), 32'(exp_hit));
        acc = v && exp_ready;
        if (mq.size() != 0 && ack) void'(mq.pop_front());
        m_br = 1'b0;
        if (acc) begin
            if (s) m_flags = {n, z, c};
            if (wr && a == 4'd15) begin
                m_br  = 1'b1;
                m_tgt = d & ~32'd1;
            end else if (wr) begin
                mq.push_back('{addr: a, data: d});
            end
        end
    endtask

    task automatic idle(input logic ack);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ack, 4'd0);
    endtask

    initial begin
        rst = 1'b0;
        res_valid = 1'b0; res_data = '0; res_addr = '0; res_wr = 1'b0;
        res_s = 1'b0; res_c = 1'b0; res_z = 1'b0; res_n = 1'b0;
        rf_ack = 1'b0; chk_addr = '0;
        model_reset();
        #12;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_apsr", 32'({apsr_n, apsr_z, apsr_c}), 32'd0);
        chk("rst_rf_addr", 32'(rf_addr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_branch", 32'({branch_req}), 32'd0);
        chk("rst_target", branch_target, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single write with flag update, acked immediately.
        step(1'b1, 4'd3, 32'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: fill with r1, r2; r4 stalls until the same-cycle pop.
        step(1'b1, 4'd1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1'b1, 4'd2, 32'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b1, 4'd4, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1'b1, 4'd4, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4);
        repeat (3) idle(1'b1);

        // PC write: branch pulse, bit 0 cleared, never enqueued.
        step(1'b1, 4'd15, 32'h101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        idle(1'b1);
        idle(1'b1);

        // Flag-only result, then write without S.
        step(1'b1, 4'd6, 32'h66, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6);
        step(1'b1, 4'd7, 32'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
        idle(1'b1);
        idle(1'b1);

        // Reset in the middle of a drain with two entries pending.
        step(1'b1, 4'd8, 32'h88, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        step(1'b1, 4'd9, 32'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        res_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("midrst_rf_we", 32'(rf_we), 32'd0);
        chk("midrst_apsr", 32'({apsr_n, apsr_z, apsr_c}), 32'd0);
        chk("midrst_branch", 32'(branch_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) idle(1'b1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? 4'd15 : ADDR_W'($urandom_range(0, 15));
            step(1'($urandom), a, $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                 ADDR_W'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
